vc_flit_tx: RTL

Output-side flit transmitter for one router output port. It drains the per-VC input buffers through their valid/ready handshake and drives a single outbound link. It arbitrates among VCs and holds a wormhole lock from a multi-flit head until its tail, so a packet never interleaves with another. It presents flits on a registered link interface tagged with the source VC id, complementing the VC buffer on the receive side.

---
 rtl/vc_flit_tx_pkg.sv | 25 ++
 rtl/vc_rr_arbiter.sv | 38 +++
 rtl/vc_flit_tx.sv | 87 ++++++++
 3 files changed

// File: rtl/vc_flit_tx_pkg.sv
// vc_flit_tx_pkg: shared sizes, flit field positions, flit type and FSM state enums.
package vc_flit_tx_pkg;
  localparam int N_VC = 3;
  localparam int FLIT_W = 34;
  localparam int VC_W = 2;
  localparam int TYPE_LSB = 32;
  localparam int SIZE_LSB = 22;
  localparam int SIZE_W = 8;
  typedef enum logic [1:0] {
    FT_HEAD = 2'b00,
    FT_BODY = 2'b01,
    FT_RSVD = 2'b10,
    FT_TAIL = 2'b11
  } flit_type_e;
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;
  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] f);
    return flit_type_e'(f[TYPE_LSB +: 2]);
  endfunction
  function automatic logic [SIZE_W-1:0] flit_size(input logic [FLIT_W-1:0] f);
    return f[SIZE_LSB +: SIZE_W];
  endfunction
endpackage

// File: rtl/vc_rr_arbiter.sv
// vc_rr_arbiter: round-robin one-hot grant starting at an internal pointer that
// moves to winner+1 when adv_i is strobed.
module vc_rr_arbiter
  import vc_flit_tx_pkg::*;
#(
  parameter int N = N_VC,
  parameter int W = VC_W
) (
  input  logic         clk,
  input  logic         arst,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);
  logic [W-1:0] ptr_q, ptr_d, win;
  logic found;
  int idx;
  always_comb begin
    gnt_o = '0;
    win = ptr_q;
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      idx = idx >= N ? idx - N : idx;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        gnt_o[idx] = 1'b1;
        win = W'(idx);
      end
    end
  end
  assign ptr_d = adv_i ? (win == W'(N - 1) ? '0 : win + W'(1)) : ptr_q;
  always_ff @(posedge clk) begin
    if (arst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/vc_flit_tx.sv
// vc_flit_tx: per-port flit transmitter with VC arbitration, wormhole lock and a
// registered link stage. Define VC_TX_RR_EN for round-robin, else highest VC wins.
module vc_flit_tx
  import vc_flit_tx_pkg::*;
(
  input  logic                   clk,
  input  logic                   arst,
  input  logic [N_VC*FLIT_W-1:0] vc_fdata_i,
  input  logic [N_VC-1:0]        vc_valid_i,
  output logic [N_VC-1:0]        vc_ready_o,
  output logic [FLIT_W-1:0]      fdata_o,
  output logic                   valid_o,
  output logic [VC_W-1:0]        vc_id_o,
  input  logic                   ready_i,
  output logic                   busy_o
);
  state_e state_q, state_d;
  logic [VC_W-1:0] lock_q, lock_d, vc_q, gidx;
  logic [FLIT_W-1:0] fdata_q, sel;
  logic valid_q, can_load, xfer, idle;
  logic [N_VC-1:0] cand, lock_oh, idle_gnt, gnt;
  assign idle = state_q == ST_IDLE;
  assign can_load = ~valid_q | ready_i;
  always_comb begin
    cand = '0;
    lock_oh = '0;
    for (int v = 0; v < N_VC; v++) begin
      cand[v] = vc_valid_i[v] & (flit_type(vc_fdata_i[v*FLIT_W +: FLIT_W]) == FT_HEAD);
      lock_oh[v] = lock_q == VC_W'(v);
    end
  end
`ifdef VC_TX_RR_EN
  logic adv;
  assign adv = xfer & idle;
  vc_rr_arbiter #(.N(N_VC), .W(VC_W)) u_arb (
    .clk   (clk),
    .arst  (arst),
    .req_i (cand),
    .adv_i (adv),
    .gnt_o (idle_gnt)
  );
`else
  always_comb begin
    idle_gnt = '0;
    for (int v = 0; v < N_VC; v++) begin
      if (cand[v]) begin
        idle_gnt = '0;
        idle_gnt[v] = 1'b1;
      end
    end
  end
`endif
  // Pops are suppressed during reset so upstream buffers keep their flits.
  assign gnt = idle ? idle_gnt : lock_oh & vc_valid_i;
  assign vc_ready_o = gnt & {N_VC{can_load & ~arst}};
  assign xfer = |vc_ready_o;
  always_comb begin
    gidx = '0;
    for (int v = 0; v < N_VC; v++) gidx = gnt[v] ? VC_W'(v) : gidx;
  end
  assign sel = vc_fdata_i[gidx*FLIT_W +: FLIT_W];
  assign state_d = !xfer ? state_q :
                   idle ? (flit_size(sel) != '0 ? ST_LOCKED : ST_IDLE) :
                   (flit_type(sel) == FT_TAIL ? ST_IDLE : ST_LOCKED);
  assign lock_d = xfer && idle ? gidx : lock_q;
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= ST_IDLE;
      lock_q <= '0;
      valid_q <= 1'b0;
      fdata_q <= '0;
      vc_q <= '0;
    end else begin
      state_q <= state_d;
      lock_q <= lock_d;
      if (can_load) valid_q <= xfer;
      if (xfer) begin
        fdata_q <= sel;
        vc_q <= gidx;
      end
    end
  end
  assign fdata_o = fdata_q;
  assign valid_o = valid_q;
  assign vc_id_o = vc_q;
  assign busy_o = state_q == ST_LOCKED;
endmodule
